// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants, reader state encoding and small helpers for the CPU
// register dump block (cpu_reg_reader and its lowest-set-bit finder).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 3;
  localparam int DROP_W   = 4;

  // Reader FSM: IDLE waits for a request, SEND streams the selected words.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rd_state_e;

  // One-hot mask with only bit 'idx' set; used to retire a sent register.
  function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh      = {NUM_REGS{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cpu_lsb_find.sv
// -----------------------------------------------------------------------------
// cpu_lsb_find
// Purely combinational lowest-set-bit finder over an 8-bit register mask.
// Ports:
//   vec   in  8  register select mask
//   idx   out 3  index of lowest set bit (0 when vec is empty)
//   found out 1  vec has at least one bit set
// -----------------------------------------------------------------------------
module cpu_lsb_find
  import cpu_pkg::*;
(
  input  logic [NUM_REGS-1:0] vec,
  output logic [IDX_W-1:0]    idx,
  output logic                found
);

  // Priority encode from bit 0 upward.
  always_comb begin
    found = |vec;
    casez (vec)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default:     idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/cpu_reg_reader.sv
// -----------------------------------------------------------------------------
// cpu_reg_reader
// Snapshots the CPU register file on a dump request and streams the selected
// registers (lowest index first) over a valid/ready word interface.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   reg1..reg8    in 32  register file values (reg1 = index 0)
//   OV            in  1  CPU overflow flag
//   rd_req        in  1  dump request pulse
//   rd_mask       in  8  register select, sampled with rd_req
//   out_ready     in  1  downstream accepts the current word
//   out_valid/out_data/out_idx/out_last  out  word stream
//   busy          out 1  dump in progress
//   ov_sticky     out 1  OV seen since the last accepted request
//   drop_cnt      out 4  saturating count of requests ignored while busy
// -----------------------------------------------------------------------------
module cpu_reg_reader
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [DATA_W-1:0] reg3,
  input  logic [DATA_W-1:0] reg4,
  input  logic [DATA_W-1:0] reg5,
  input  logic [DATA_W-1:0] reg6,
  input  logic [DATA_W-1:0] reg7,
  input  logic [DATA_W-1:0] reg8,
  input  logic              OV,
  input  logic              rd_req,
  input  logic [NUM_REGS-1:0] rd_mask,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              ov_sticky,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  rd_state_e           state_r, state_nxt_s;
  logic [NUM_REGS-1:0] mask_r, mask_nxt_s;
  logic [DATA_W-1:0]   snap_r [NUM_REGS];
  logic [DATA_W-1:0]   regs_s [NUM_REGS];

  logic                accept_s, xfer_s, drop_s;
  logic [IDX_W-1:0]    lsb_idx_s;
  logic                lsb_found_s;
  logic [NUM_REGS-1:0] rem_s;
  logic [IDX_W-1:0]    rem_idx_s;
  logic                rem_found_s;

  logic                out_valid_r, out_last_r, busy_r, ov_sticky_r;
  logic [DATA_W-1:0]   out_data_r;
  logic [IDX_W-1:0]    out_idx_r;
  logic [DROP_W-1:0]   drop_cnt_r;

  logic                valid_nxt_s, last_nxt_s;
  logic [DATA_W-1:0]   data_nxt_s;
  logic [IDX_W-1:0]    idx_nxt_s;

  // Gather the flat register ports into an indexable array.
  always_comb begin
    regs_s[0] = reg1;
    regs_s[1] = reg2;
    regs_s[2] = reg3;
    regs_s[3] = reg4;
    regs_s[4] = reg5;
    regs_s[5] = reg6;
    regs_s[6] = reg7;
    regs_s[7] = reg8;
  end

  // Next-state and remaining-mask logic of the reader FSM.
  always_comb begin
    state_nxt_s = state_r;
    mask_nxt_s  = mask_r;
    accept_s    = 1'b0;
    xfer_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_req && (rd_mask != {NUM_REGS{1'b0}})) begin
          accept_s    = 1'b1;
          mask_nxt_s  = rd_mask;
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (out_valid_r && out_ready) begin
          xfer_s     = 1'b1;
          mask_nxt_s = mask_r & ~idx_onehot(out_idx_r);
          if (mask_nxt_s == {NUM_REGS{1'b0}}) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_SEND;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        mask_nxt_s  = {NUM_REGS{1'b0}};
      end
    endcase
  end

  // Requests arriving while a dump is still in SEND (even on its final
  // transfer edge) are dropped and counted.
  assign drop_s = rd_req && (state_r == ST_SEND);

  // Word to present next: lowest remaining bit.
  cpu_lsb_find u_lsb_cur (
    .vec   (mask_nxt_s),
    .idx   (lsb_idx_s),
    .found (lsb_found_s)
  );

  // That word is the last one when nothing remains above it.
  assign rem_s = mask_nxt_s & ~idx_onehot(lsb_idx_s);

  cpu_lsb_find u_lsb_last (
    .vec   (rem_s),
    .idx   (rem_idx_s),
    .found (rem_found_s)
  );

  // Next values of the registered word stream outputs.
  always_comb begin
    valid_nxt_s = (state_nxt_s == ST_SEND) && lsb_found_s;
    data_nxt_s  = out_data_r;
    idx_nxt_s   = out_idx_r;
    last_nxt_s  = out_last_r;
    if (accept_s) begin
      // First word comes straight from the live registers being snapshotted.
      data_nxt_s = regs_s[lsb_idx_s];
      idx_nxt_s  = lsb_idx_s;
      last_nxt_s = ~rem_found_s;
    end else if (xfer_s && (state_nxt_s == ST_SEND)) begin
      data_nxt_s = snap_r[lsb_idx_s];
      idx_nxt_s  = lsb_idx_s;
      last_nxt_s = ~rem_found_s;
    end else if (state_nxt_s == ST_IDLE) begin
      data_nxt_s = {DATA_W{1'b0}};
      idx_nxt_s  = {IDX_W{1'b0}};
      last_nxt_s = 1'b0;
    end else begin
      // Stalled: hold the presented word.
      data_nxt_s = out_data_r;
      idx_nxt_s  = out_idx_r;
      last_nxt_s = out_last_r;
    end
  end

  // FSM state and remaining mask registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      mask_r  <= {NUM_REGS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      mask_r  <= mask_nxt_s;
    end
  end

  // Register snapshot, captured only on an accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snap_r[i] <= {DATA_W{1'b0}};
      end
    end else if (accept_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snap_r[i] <= regs_s[i];
      end
    end
  end

  // Output stream and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_idx_r   <= {IDX_W{1'b0}};
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      ov_sticky_r <= 1'b0;
      drop_cnt_r  <= {DROP_W{1'b0}};
    end else begin
      out_valid_r <= valid_nxt_s;
      out_data_r  <= data_nxt_s;
      out_idx_r   <= idx_nxt_s;
      out_last_r  <= last_nxt_s;
      busy_r      <= (state_nxt_s == ST_SEND);
      // OV on the accept edge wins over the clear.
      if (OV) begin
        ov_sticky_r <= 1'b1;
      end else if (accept_s) begin
        ov_sticky_r <= 1'b0;
      end
      if (drop_s && (drop_cnt_r != DROP_MAX)) begin
        drop_cnt_r <= drop_cnt_r + DROP_ONE;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign ov_sticky = ov_sticky_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: doc/cpu_reg_reader.md
CPU_REG_READER -- requirements
Module: cpu_reg_reader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: reg1..reg8  input  32 each  CPU register file outputs; reg1=index 0 (RSM 000) ... reg8=index 7 (RSM 111).
REQ-004 SHALL have port: OV  input  1  CPU overflow flag.
REQ-005 SHALL have port: rd_req  input  1  single-cycle dump request.
REQ-006 SHALL have port: rd_mask  input  8  register select, bit i = index i; sampled with rd_req.
REQ-007 SHALL have port: out_ready  input  1  downstream accepts current word.
REQ-008 SHALL have ports: out_valid  output  1 / out_data  output  32 / out_idx  output  3 / out_last  output  1  word stream.
REQ-009 SHALL have ports: busy  output  1 / ov_sticky  output  1 / drop_cnt  output  4  status.

Function
REQ-010 SHALL implement states IDLE and SEND; busy=1 exactly in SEND.
REQ-011 IDLE, rd_req=1, rd_mask!=0: SHALL snapshot reg1..reg8 and rd_mask on that edge, enter SEND; out_valid=1 from next cycle (latency 1).
REQ-012 IDLE, rd_req=1, rd_mask=0: SHALL ignore request, stay IDLE, no output.
REQ-013 SEND: out_idx SHALL be lowest set bit of remaining mask; out_data = snapshot[out_idx].
REQ-014 Transfer occurs when out_valid&&out_ready; SHALL clear that mask bit and advance to next higher set bit the following cycle.
REQ-015 out_last SHALL be 1 when current word is the highest set bit of remaining mask.
REQ-016 Transfer with out_last=1: SHALL return to IDLE, out_valid=0 next cycle.
REQ-017 out_valid&&!out_ready: out_data, out_idx, out_last SHALL hold stable; no advance.
REQ-018 Snapshot SHALL be immune to reg1..reg8 changes during SEND (dump reflects request-cycle values).
REQ-019 rd_req during SEND SHALL be ignored and increment drop_cnt, saturating at 15.
REQ-020 rd_req on the same edge as a last transfer SHALL be treated as in SEND (dropped); a new request is accepted only in IDLE.
REQ-021 ov_sticky SHALL set on any cycle OV=1; cleared by an accepted request (REQ-011), with OV=1 on that same edge taking priority (remains set).
REQ-022 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-023 Minimum dump is 1 word (1 cycle at out_ready=1); maximum 8 words, back-to-back at full throughput.

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, ov_sticky=0, drop_cnt=0, snapshot and mask cleared.
REQ-025 Reset mid-dump SHALL abort; no further words after release until a new request.
REQ-026 First request accepted on the first rising edge with reset=1.

Structure
REQ-027 Shared package cpu_pkg SHALL hold NUM_REGS=8, DATA_W=32, IDX_W=3, DROP_W=4 and the reader state enum.
REQ-028 Lowest-set-bit finder SHALL be sub-module cpu_lsb_find (8-bit in -> 3-bit index, found flag), also used for last detection.

Verification
REQ-029 Regs 51,32,0,FFFFFFFF,51,0,51,0; rd_mask=FF, out_ready=1 -> 8 words idx 0..7 in consecutive cycles, data as listed, out_last only at idx 7.
REQ-030 rd_mask=8'b0100_0101, out_ready toggling 1/0 -> words idx 0,2,6 (51,0,51), data held during stalls, out_last at idx 6.
REQ-031 rd_mask=0 -> no out_valid, busy=0; then rd_req during SEND x3 -> drop_cnt=3; x20 -> 15.
REQ-032 Change reg1 51->99 during dump of FF -> idx 0 reports 51.
REQ-033 OV pulse 1 cycle -> ov_sticky=1 until next accepted request; OV=1 on accept edge -> stays 1.
REQ-034 reset=0 asserted at 3rd word of FF dump -> all outputs 0 immediately; no words after release.
